pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard-detection and operand-forwarding unit for the in-order MIPS pipeline. It sits beside the decode stage. It keeps its own shift register of destination tags for every downstream stage (EX, ME, WB by default). From those tags it makes three decisions each cycle: the load-use stall, the forwarding select and forwarded operand for each ID source, and the bubble insertion on stall or flush. The pipeline depth, the load-result availability stage and the data width are parameters, so deeper pipelines reuse the block unchanged.

## Interface
- STAGES, 3, number of tracked stages after ID; index 0 = EX, STAGES-1 = WB
- LOAD_READY, 1, lowest stage index whose `stage_data` carries load data; must be < STAGES
- DATA_W, 32, operand width
- RA_W, 5, register address width
- SEL_W, $clog2(STAGES+1), forwarding select width
- clock  in  1  rising-edge clock
- reset_0  in  1  synchronous, active-high reset
- hold  in  1  whole-pipeline freeze (memory wait); tags do not advance
- flush  in  1  kill the instruction currently in ID (taken branch/jump)
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W  ID source registers
- id_use_rs, id_use_rt  in  1  source actually read
- id_rd  in  RA_W  ID destination register
- id_wreg  in  1  ID instruction writes a register
- id_load  in  1  ID instruction is a load
- rf_a, rf_b  in  DATA_W  register-file read data
- stage_data  in  STAGES*DATA_W  result bus of stage k at bits [k*DATA_W +: DATA_W]
- stall  out  1  hold PC and IF/ID; bubble inserted into EX
- fwd_a_sel, fwd_b_sel  out  SEL_W  0 = register file, k+1 = stage k
- op_a, op_b  out  DATA_W  forwarded operands

## Operation
- Each stage tag holds {valid, rd, wreg, load}.
- A tag matches source r when all of these hold: valid, wreg, rd == r, r != 0, and the source's use flag is set.
- For each source, take the lowest-index matching stage k (the youngest producer).
  - If the producer is a load and k < LOAD_READY, the hazard is unresolved.
  - Otherwise sel = k+1 and op = stage_data[k].
  - With no match, sel = 0 and op = rf.
- `stall` = id_valid & !flush & (unresolved hazard on rs or rt).
- While stall is asserted, sel and op still follow the rules above; the top ignores them.
- Register 0 never matches, so no stall and no forwarding on $zero.
- Tag update on each rising edge, in priority order:
  - reset_0: all valid bits cleared.
  - Else hold: all tags keep their value.
  - Else: tag[k] <= tag[k-1] for k ≥ 1; tag[0] <= {id_valid & !stall & !flush, id_rd, id_wreg, id_load}. A stalled or flushed slot enters EX as a bubble.
- flush overrides stall in the same cycle: stall = 0 and a bubble is inserted.
- The WB stage (k = STAGES-1) is forwarded, so the result does not depend on register-file write-before-read ordering.

## Timing
- stall, sel and op are combinational from the registered tags and the current ID inputs; zero-cycle latency.
- While reset_0 = 1: stall = 0 and sel = 0, forced. From the first edge after reset, all tags are invalid.
- A load in ID followed by a dependent instruction stalls for exactly LOAD_READY cycles (1 by default). Forwarding happens in the cycle the stall drops.
- hold freezes tag state. Outputs keep being evaluated from the frozen tags and the current ID inputs.
- hold and flush together: the tags stay frozen, so the flush bubble is not recorded. The top keeps flush asserted until hold drops.

## Configuration
- PIPE_HAZ_PERF_EN defined:
  - Adds output ports stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each edge where stall & !hold; flush_cnt increments on each edge where flush & !hold.
  - Both saturate at 32'hFFFF_FFFF and clear on reset_0.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- Back-to-back ALU dependency: `add $3` in EX, ID reads rs=$3 with stage_data[0]=32'h1234 → stall=0, fwd_a_sel=1, op_a=32'h1234.
- Load-use: `lw $5` in EX (load), ID uses rt=$5 → stall=1 for one cycle. Next cycle the tag is in ME → stall=0, fwd_b_sel=2, op_b=stage_data[1]. A bubble is observed in EX.
- Multiple producers: $7 written in EX (data 32'hA) and WB (data 32'hB), ID reads $7 → sel=1, op=32'hA (youngest wins).
- $zero: EX writes $0 with wreg=1, ID reads $0 → sel=0, op=rf, stall=0.
- flush during load-use stall → stall=0, tag[0].valid=0 after the edge. With PIPE_HAZ_PERF_EN: flush_cnt +1, stall_cnt unchanged.
- hold for 3 cycles with a load in EX and a dependent instruction in ID → stall stays 1 and the tags do not move. Release hold → stall drops after one more edge. Assert reset_0 mid-sequence → all sel=0, stall=0, counters cleared.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Load-use stall detection and operand forwarding for an in-order pipeline, driven by private per-stage destination tags.
// Optional PIPE_HAZ_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_unit #(
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 1,
  parameter int DATA_W     = 32,
  parameter int RA_W       = 5,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                     clock,
  input  logic                     reset_0,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [RA_W-1:0]          id_rs,
  input  logic [RA_W-1:0]          id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [RA_W-1:0]          id_rd,
  input  logic                     id_wreg,
  input  logic                     id_load,
  input  logic [DATA_W-1:0]        rf_a,
  input  logic [DATA_W-1:0]        rf_b,
  input  logic [STAGES*DATA_W-1:0] stage_data,
`ifdef PIPE_HAZ_PERF_EN
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt,
`endif
  output logic                     stall,
  output logic [SEL_W-1:0]         fwd_a_sel,
  output logic [SEL_W-1:0]         fwd_b_sel,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b
);

  logic            valid_q [STAGES];
  logic [RA_W-1:0] rd_q    [STAGES];
  logic            wreg_q  [STAGES];
  logic            load_q  [STAGES];

  logic [SEL_W-1:0]  sel_a_d, sel_b_d;
  logic [DATA_W-1:0] op_a_d, op_b_d;
  logic              unres_a_d, unres_b_d;
  logic              stall_d;

  // Scan oldest to youngest so the lowest-index (youngest) producer wins.
  always_comb begin
    sel_a_d   = '0;
    op_a_d    = rf_a;
    unres_a_d = 1'b0;
    sel_b_d   = '0;
    op_b_d    = rf_b;
    unres_b_d = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (valid_q[k] && wreg_q[k] && (rd_q[k] == id_rs) && (id_rs != '0) && id_use_rs) begin
        sel_a_d   = SEL_W'(k + 1);
        op_a_d    = stage_data[k*DATA_W +: DATA_W];
        unres_a_d = load_q[k] && (k < LOAD_READY);
      end
      if (valid_q[k] && wreg_q[k] && (rd_q[k] == id_rt) && (id_rt != '0) && id_use_rt) begin
        sel_b_d   = SEL_W'(k + 1);
        op_b_d    = stage_data[k*DATA_W +: DATA_W];
        unres_b_d = load_q[k] && (k < LOAD_READY);
      end
    end
  end

  assign stall_d   = ~reset_0 & id_valid & ~flush & (unres_a_d | unres_b_d);
  assign stall     = stall_d;
  assign fwd_a_sel = reset_0 ? '0 : sel_a_d;
  assign fwd_b_sel = reset_0 ? '0 : sel_b_d;
  assign op_a      = reset_0 ? rf_a : op_a_d;
  assign op_b      = reset_0 ? rf_b : op_b_d;

  always_ff @(posedge clock) begin
    if (reset_0) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        wreg_q[k]  <= 1'b0;
        load_q[k]  <= 1'b0;
      end
    end else if (!hold) begin
      valid_q[0] <= id_valid & ~stall_d & ~flush;
      rd_q[0]    <= id_rd;
      wreg_q[0]  <= id_wreg;
      load_q[0]  <= id_load;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        wreg_q[k]  <= wreg_q[k-1];
        load_q[k]  <= load_q[k-1];
      end
    end
  end

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset_0) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!hold) begin
      if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed + randomized bench for pipe_hazard_unit against a producer-list reference model.
module tb_pipe_hazard_unit;
  localparam int STAGES = 3;
  localparam int LR     = 1;
  localparam int DW     = 32;
  localparam int RW     = 5;
  localparam int SW     = $clog2(STAGES + 1);

  logic clock = 1'b0;
  logic reset_0, hold, flush, id_valid;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic id_use_rs, id_use_rt, id_wreg, id_load;
  logic [DW-1:0] rf_a, rf_b;
  logic [STAGES*DW-1:0] stage_data;
  logic stall;
  logic [SW-1:0] fwd_a_sel, fwd_b_sel;
  logic [DW-1:0] op_a, op_b;
`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_unit dut (
    .clock(clock), .reset_0(reset_0), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_wreg(id_wreg), .id_load(id_load), .rf_a(rf_a), .rf_b(rf_b),
    .stage_data(stage_data),
`ifdef PIPE_HAZ_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .op_a(op_a), .op_b(op_b)
  );

  always #5 clock = ~clock;

  // Reference: list of in-flight instructions, index 0 = youngest (EX).
  typedef struct {
    bit          valid;
    bit [RW-1:0] rd;
    bit          wreg;
    bit          load;
  } instr_t;

  instr_t      pipe [STAGES];
  int unsigned m_scnt, m_fcnt;
  int          vectors, miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Youngest writer of r decides; a load younger than the ready stage cannot be forwarded yet.
  task automatic ref_src(input logic [RW-1:0] r, input logic use_r, input logic [DW-1:0] rf,
                         output int sel, output logic [DW-1:0] op, output bit unres);
    sel = 0; op = rf; unres = 0;
    for (int k = 0; k < STAGES; k++) begin
      if (pipe[k].valid && pipe[k].wreg && pipe[k].rd == r && r != 0 && use_r) begin
        sel   = k + 1;
        op    = stage_data[k*DW +: DW];
        unres = pipe[k].load && (k < LR);
        break;
      end
    end
  endtask

  bit exp_stall;

  task automatic step();
    int sa, sb;
    logic [DW-1:0] oa, ob;
    bit ua, ub;
    #1;
    ref_src(id_rs, id_use_rs, rf_a, sa, oa, ua);
    ref_src(id_rt, id_use_rt, rf_b, sb, ob, ub);
    exp_stall = !reset_0 && id_valid && !flush && (ua || ub);
    check("stall", 32'(stall), 32'(exp_stall));
    if (reset_0) begin
      check("rst_sel_a", 32'(fwd_a_sel), 32'd0);
      check("rst_sel_b", 32'(fwd_b_sel), 32'd0);
    end else begin
      if (!ua) begin
        check("sel_a", 32'(fwd_a_sel), 32'(sa));
        check("op_a", op_a, oa);
      end
      if (!ub) begin
        check("sel_b", 32'(fwd_b_sel), 32'(sb));
        check("op_b", op_b, ob);
      end
    end
    @(posedge clock);
    if (reset_0) begin
      for (int k = 0; k < STAGES; k++) pipe[k].valid = 0;
      m_scnt = 0; m_fcnt = 0;
    end else if (!hold) begin
      for (int k = STAGES - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0].valid = id_valid && !exp_stall && !flush;
      pipe[0].rd    = id_rd;
      pipe[0].wreg  = id_wreg;
      pipe[0].load  = id_load;
      if (exp_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
    end
    @(negedge clock);
`ifdef PIPE_HAZ_PERF_EN
    check("stall_cnt", stall_cnt, m_scnt);
    check("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  task automatic issue(input bit v, input logic [RW-1:0] rd, input bit w, input bit ld,
                       input logic [RW-1:0] rs, input bit urs, input logic [RW-1:0] rt, input bit urt);
    id_valid = v; id_rd = rd; id_wreg = w; id_load = ld;
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
  endtask

  initial begin
    vectors = 0; miscompares = 0; m_scnt = 0; m_fcnt = 0;
    for (int k = 0; k < STAGES; k++) pipe[k] = '{0, 0, 0, 0};
    reset_0 = 1; hold = 0; flush = 0;
    rf_a = 32'hAAAA_0001; rf_b = 32'hBBBB_0002;
    stage_data = {32'h0000_0B0B, 32'h0000_0A0A, 32'h0000_0909};
    issue(1, 5'd3, 1, 1, 5'd3, 1, 5'd3, 1);
    step(); step();
    reset_0 = 0;

    // Back-to-back ALU dependency
    issue(1, 5'd3, 1, 0, 5'd0, 0, 5'd0, 0);
    step();
    stage_data[0 +: DW] = 32'h1234;
    issue(1, 5'd4, 1, 0, 5'd3, 1, 5'd0, 0);
    #1;
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_sel", 32'(fwd_a_sel), 32'd1);
    check("alu_op", op_a, 32'h1234);
    step();

    // Load-use: one stall cycle, then forward from ME
    issue(1, 5'd5, 1, 1, 5'd0, 0, 5'd0, 0);
    step();
    stage_data[DW +: DW] = 32'h5555;
    issue(1, 5'd6, 1, 0, 5'd0, 0, 5'd5, 1);
    #1 check("lu_stall", 32'(stall), 32'd1);
    step();
    check("lu_stall_drop", 32'(stall), 32'd0);
    check("lu_sel", 32'(fwd_b_sel), 32'd2);
    check("lu_op", op_b, 32'h5555);
    step();

    // Multiple producers of $7: youngest wins
    issue(1, 5'd7, 1, 0, 5'd0, 0, 5'd0, 0); step();
    issue(1, 5'd8, 0, 0, 5'd0, 0, 5'd0, 0); step();
    issue(1, 5'd7, 1, 0, 5'd0, 0, 5'd0, 0); step();
    stage_data = {32'hB, 32'h0, 32'hA};
    issue(1, 5'd9, 0, 0, 5'd7, 1, 5'd7, 1);
    #1;
    check("multi_sel", 32'(fwd_a_sel), 32'd1);
    check("multi_op", op_a, 32'hA);
    step();

    // $zero never forwards
    issue(1, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0); step();
    issue(1, 5'd1, 1, 0, 5'd0, 1, 5'd0, 1);
    #1;
    check("zero_sel", 32'(fwd_a_sel), 32'd0);
    check("zero_op", op_b, rf_b);
    step();

    // Flush during load-use
    issue(1, 5'd9, 1, 1, 5'd0, 0, 5'd0, 0); step();
    issue(1, 5'd2, 1, 0, 5'd9, 1, 5'd0, 0);
    flush = 1;
    #1 check("flush_stall", 32'(stall), 32'd0);
    step();
    flush = 0;
    #1 check("flush_bubble_sel", 32'(fwd_a_sel), 32'd2);
    step();

    // Hold with load in EX and dependent in ID
    issue(1, 5'd10, 1, 1, 5'd0, 0, 5'd0, 0); step();
    issue(1, 5'd11, 1, 0, 5'd10, 1, 5'd0, 0);
    hold = 1;
    for (int i = 0; i < 3; i++) step();
    hold = 0;
    #1 check("hold_rel_stall", 32'(stall), 32'd1);
    step();
    check("hold_drop", 32'(stall), 32'd0);
    step();
    issue(1, 5'd12, 1, 1, 5'd0, 0, 5'd0, 0); step();
    issue(1, 5'd13, 1, 0, 5'd12, 1, 5'd12, 1);
    reset_0 = 1;
    step();
    reset_0 = 0;
    step();

    // Randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      reset_0 = ($urandom_range(0, 99) < 2);
      hold    = ($urandom_range(0, 99) < 12);
      flush   = ($urandom_range(0, 99) < 10);
      issue($urandom_range(0, 9) < 8, RW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            RW'($urandom_range(0, 3)), 1'($urandom), RW'($urandom_range(0, 3)), 1'($urandom));
      rf_a = $urandom; rf_b = $urandom;
      stage_data = {$urandom, $urandom, $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
